// File: rtl/snn_pkg.sv
// Shared definitions for the spiking front end: default geometry, encoder
// state encoding and the pixel / spike-vector types that mac also consumes.
package snn_pkg;

  localparam int N_PIX_DEF   = 25;
  localparam int PIX_W_DEF   = 8;
  localparam int T_STEPS_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } enc_state_t;

  typedef logic [PIX_W_DEF-1:0] pix_t;
  typedef logic [N_PIX_DEF-1:0] spk_vec_t;

endpackage

// File: rtl/spike_acc_cell.sv
// One pixel lane of the rate encoder: a phase accumulator whose carry-out
// is the spike bit for the vector currently presented.
module spike_acc_cell
  import snn_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [PIX_W-1:0] pix_q,
  output logic             spike,
  output logic [PIX_W-1:0] acc
);

  logic [PIX_W:0] sum;

  // acc holds t*p mod 2^PIX_W while vector t is presented; wrap is intended.
  assign sum   = {1'b0, acc} + {1'b0, pix_q};
  assign spike = sum[PIX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (adv) begin
      acc <= sum[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike generator: captures a pixel frame and streams T_STEPS
// spike vectors over a valid/ready interface toward the mac block.
//
// state | meaning
// IDLE  | no frame; waiting for load, outputs forced to zero
// GEN   | frame in progress; vector t_idx presented, advances on spk_ready
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter  int N_PIX   = N_PIX_DEF,
  parameter  int PIX_W   = PIX_W_DEF,
  parameter  int T_STEPS = T_STEPS_DEF,
  localparam int TW      = $clog2(T_STEPS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [N_PIX*PIX_W-1:0] pix_in,
  output logic                   busy,
  output logic                   spk_valid,
  input  logic                   spk_ready,
  output logic [N_PIX-1:0]       spk_out,
  output logic [TW-1:0]          t_idx,
  output logic                   frame_last
);

  enc_state_t       state;
  enc_state_t       state_nxt;
  logic [PIX_W-1:0] pix_q [N_PIX];
  logic [PIX_W-1:0] acc_unused [N_PIX];
  logic [N_PIX-1:0] spk_raw;
  logic             start;
  logic             xfer;
  logic             last;

  assign start = (state == IDLE) && load;
  assign xfer  = spk_valid && spk_ready;
  assign last  = (t_idx == TW'(T_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    spk_valid  = 1'b0;
    spk_out    = '0;
    frame_last = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = GEN;
        end
      end
      GEN: begin
        busy       = 1'b1;
        spk_valid  = 1'b1;
        spk_out    = spk_raw;
        frame_last = last;
        if (spk_ready && last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_idx <= '0;
    end else if (start) begin
      t_idx <= '0;
    end else if (xfer) begin
      t_idx <= last ? '0 : t_idx + TW'(1);
    end
  end

  // Pixels are frozen for the whole frame; pix_in is only looked at on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIX; i++) begin
        pix_q[i] <= '0;
      end
    end else if (start) begin
      for (int i = 0; i < N_PIX; i++) begin
        pix_q[i] <= pix_in[i*PIX_W +: PIX_W];
      end
    end
  end

  for (genvar g = 0; g < N_PIX; g++) begin : g_lane
    spike_acc_cell #(
      .PIX_W (PIX_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .adv   (xfer),
      .pix_q (pix_q[g]),
      .spike (spk_raw[g]),
      .acc   (acc_unused[g])
    );
  end

endmodule
